spi_arbiter: RTL

SPI_ARBITER -- requirements
Module: spi_arbiter

---
 rtl/spi_pkg.sv | 20 ++
 rtl/rr_arbiter.sv | 33 +++
 rtl/spi_arbiter.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master arbiter: FSM encoding, default
// parameter values and a small width helper.
package spi_pkg;

    localparam int DEF_NUM_REQ     = 3;
    localparam int DEF_DATA_W      = 16;
    localparam int DEF_TIMEOUT_CYC = 4096;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_WAIT   = 2'd2,
        ST_FINISH = 2'd3
    } state_t;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin winner select: the search starts one past last_served and
// wraps, returning a one-hot winner (all zero when nothing is requested).
module rr_arbiter
    import spi_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int IDX_W   = idx_width(DEF_NUM_REQ)
)(
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_served,
    output logic [NUM_REQ-1:0] winner
);

    logic found_s;
    logic hit_s;

    // Walk candidates in rotated priority order; first active request wins.
    always_comb begin
        winner  = '0;
        found_s = 1'b0;
        hit_s   = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            for (int j = 0; j < NUM_REQ; j++) begin
                hit_s = !found_s && req[j] &&
                        ((int'(last_served) + k == j) ||
                         (int'(last_served) + k == j + NUM_REQ));
                winner[j] = winner[j] | hit_s;
                found_s   = found_s | hit_s;
            end
        end
    end

endmodule

// File: rtl/spi_arbiter.sv
// Shares one spi_master among NUM_REQ requesters: round-robin grant, one
// start pulse per transfer, timeout watchdog and a registered result per done.
module spi_arbiter
    import spi_pkg::*;
#(
    parameter int NUM_REQ     = DEF_NUM_REQ,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
)(
    input  logic                      sys_clk,
    input  logic                      sys_rst_n,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [2*NUM_REQ-1:0]      req_mode,
    input  logic [DATA_W*NUM_REQ-1:0] req_sdata,
    output logic [NUM_REQ-1:0]        grant,
    output logic [NUM_REQ-1:0]        done,
    output logic                      err,
    output logic [DATA_W-1:0]         rdata,
    output logic                      busy,
    output logic                      spi_en,
    output logic [1:0]                spi_mode,
    output logic [DATA_W-1:0]         spi_sdata,
    input  logic [DATA_W-1:0]         spi_rdata,
    input  logic                      spi_done
);

    localparam int IDX_W = idx_width(NUM_REQ);
    localparam int CNT_W = idx_width(TIMEOUT_CYC);
    // The counter is 0 in the first WAIT cycle, so giving up when it is about
    // to reach TIMEOUT_CYC-1 puts done exactly TIMEOUT_CYC cycles after spi_en.
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYC - 2);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [IDX_W-1:0] LAST_RST  = IDX_W'(NUM_REQ - 1);

    state_t               state_r, state_s;
    logic [NUM_REQ-1:0]   winner_s;
    logic [IDX_W-1:0]     win_idx_s;
    logic [1:0]           win_mode_s;
    logic [DATA_W-1:0]    win_sdata_s;
    logic [IDX_W-1:0]     owner_r, owner_s;
    logic [IDX_W-1:0]     last_r, last_s;
    logic [CNT_W-1:0]     cnt_r, cnt_s;
    logic                 timeout_s;
    logic [NUM_REQ-1:0]   grant_r, grant_s;
    logic [NUM_REQ-1:0]   done_r, done_s;
    logic                 err_r, err_s;
    logic [DATA_W-1:0]    rdata_r, rdata_s;
    logic                 busy_r;
    logic                 spi_en_r, spi_en_s;
    logic [1:0]           spi_mode_r, spi_mode_s;
    logic [DATA_W-1:0]    spi_sdata_r, spi_sdata_s;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr (
        .req         (req),
        .last_served (last_r),
        .winner      (winner_s)
    );

    assign timeout_s = (cnt_r == CNT_LIMIT);

    // Encode the one-hot winner and pick its mode/data slices.
    always_comb begin
        win_idx_s   = '0;
        win_mode_s  = '0;
        win_sdata_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            win_idx_s   = win_idx_s | (winner_s[i] ? IDX_W'(i) : '0);
            win_mode_s  = win_mode_s | ({2{winner_s[i]}} & req_mode[2*i +: 2]);
            win_sdata_s = win_sdata_s | ({DATA_W{winner_s[i]}} & req_sdata[DATA_W*i +: DATA_W]);
        end
    end

    // State register.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (|req) begin
                    state_s = ST_LAUNCH;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_LAUNCH: state_s = ST_WAIT;
            ST_WAIT: begin
                if (spi_done || timeout_s) begin
                    state_s = ST_FINISH;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_FINISH: state_s = ST_IDLE;
            default:   state_s = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs and datapath.
    always_comb begin
        grant_s     = grant_r;
        done_s      = '0;
        err_s       = 1'b0;
        rdata_s     = rdata_r;
        spi_en_s    = 1'b0;
        spi_mode_s  = spi_mode_r;
        spi_sdata_s = spi_sdata_r;
        cnt_s       = cnt_r;
        owner_s     = owner_r;
        last_s      = last_r;
        case (state_r)
            ST_IDLE: begin
                if (|req) begin
                    grant_s     = winner_s;
                    owner_s     = win_idx_s;
                    spi_mode_s  = win_mode_s;
                    spi_sdata_s = win_sdata_s;
                    spi_en_s    = 1'b1;
                end else begin
                    grant_s = '0;
                end
            end
            ST_LAUNCH: cnt_s = '0;
            ST_WAIT: begin
                // A real completion beats a timeout landing in the same cycle.
                if (spi_done) begin
                    rdata_s = spi_rdata;
                    done_s  = grant_r;
                end else if (timeout_s) begin
                    rdata_s = '0;
                    done_s  = grant_r;
                    err_s   = 1'b1;
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            ST_FINISH: begin
                grant_s = '0;
                last_s  = owner_r;
            end
            default: begin
                grant_s = '0;
            end
        endcase
    end

    // Output and datapath registers.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            grant_r     <= '0;
            done_r      <= '0;
            err_r       <= 1'b0;
            rdata_r     <= '0;
            busy_r      <= 1'b0;
            spi_en_r    <= 1'b0;
            spi_mode_r  <= 2'b00;
            spi_sdata_r <= '0;
            cnt_r       <= '0;
            owner_r     <= '0;
            last_r      <= LAST_RST;
        end else begin
            grant_r     <= grant_s;
            done_r      <= done_s;
            err_r       <= err_s;
            rdata_r     <= rdata_s;
            busy_r      <= (state_s != ST_IDLE);
            spi_en_r    <= spi_en_s;
            spi_mode_r  <= spi_mode_s;
            spi_sdata_r <= spi_sdata_s;
            cnt_r       <= cnt_s;
            owner_r     <= owner_s;
            last_r      <= last_s;
        end
    end

    assign grant     = grant_r;
    assign done      = done_r;
    assign err       = err_r;
    assign rdata     = rdata_r;
    assign busy      = busy_r;
    assign spi_en    = spi_en_r;
    assign spi_mode  = spi_mode_r;
    assign spi_sdata = spi_sdata_r;

endmodule
